// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised RAM (ram_param / ram_array).
package ram_pkg;

  typedef enum logic {CLEAR, READY} state_e;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  // Widest data word the parity helper covers; callers zero-extend.
  localparam int PAR_MAX_W = 64;

  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Pure storage for ram_param: synchronous write, registered read and an
// optional second output register when READ_LAT is 2.
module ram_array
  import ram_pkg::*;
#(
  parameter int MEM_W    = 16,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [MEM_W-1:0]  wdata,
  output logic [MEM_W-1:0]  rdata
);

  logic [MEM_W-1:0] mem [DEPTH];
  logic [MEM_W-1:0] rd_q;

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  // Only the read registers are reset, so rdata is zero out of reset.
  always_ff @(posedge clk or negedge rst)
    if (!rst)    rd_q <= '0;
    else if (re) rd_q <= mem[addr];

  if (READ_LAT == READ_LAT_MAX) begin : g_out_reg
    logic             re_q;
    logic [MEM_W-1:0] out_q;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        re_q  <= 1'b0;
        out_q <= '0;
      end else begin
        re_q <= re;
        if (re_q) out_q <= rd_q;
      end
    assign rdata = out_q;
  end else begin : g_no_out_reg
    assign rdata = rd_q;
  end

endmodule

// File: rtl/ram_param.sv
// Single-port RAM with valid/ready requests, pipelined read response and a
// post-reset clear engine. Define RAM_PARITY_EN to add even parity and rsp_perr.
module ram_param
  import ram_pkg::*;
#(
  parameter int              DATA_W    = 16,
  parameter int              ADDR_W    = 6,
  parameter int              DEPTH     = 64,
  parameter int              READ_LAT  = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
`ifdef RAM_PARITY_EN
  ,
  output logic              rsp_perr
`endif
);

  // Illegal latencies clamp to the nearest supported value.
  localparam int STAGES = (READ_LAT > READ_LAT_MIN) ? READ_LAT_MAX : READ_LAT_MIN;
`ifdef RAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
  logic [STAGES:1]   err_pipe_q, err_pipe_d;

  logic              clearing, xfer, in_range, rd_acc;
  logic              arr_we, arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [MEM_W-1:0]  arr_wdata, arr_rdata, clr_word, req_word;

`ifdef RAM_PARITY_EN
  assign clr_word = {even_par(PAR_MAX_W'(CLEAR_VAL)), CLEAR_VAL};
  assign req_word = {even_par(PAR_MAX_W'(req_wdata)), req_wdata};
`else
  assign clr_word = CLEAR_VAL;
  assign req_word = req_wdata;
`endif

  assign clearing  = (state_q == CLEAR);
  assign req_ready = (state_q == READY);
  assign init_done = (state_q == READY);
  assign xfer      = req_valid && req_ready;
  assign in_range  = ({1'b0, req_addr} < DEPTH_L);
  assign rd_acc    = xfer && !req_we;

  assign arr_we    = clearing || (xfer && req_we && in_range);
  assign arr_re    = rd_acc && in_range;
  assign arr_addr  = clearing ? cnt_q : req_addr;
  assign arr_wdata = clearing ? clr_word : req_word;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = READY;
      end
      READY:   ;
      default: state_d = CLEAR;
    endcase
  end

  // Err bits only move with a valid entry so the last response's error
  // (and therefore the zeroed rdata) persists while rsp_valid is low.
  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    err_pipe_d    = err_pipe_q;
    vld_pipe_d[1] = rd_acc;
    if (rd_acc) err_pipe_d[1] = !in_range;
    for (int i = 2; i <= STAGES; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      if (vld_pipe_q[i-1]) err_pipe_d[i] = err_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      err_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= vld_pipe_d;
      err_pipe_q <= err_pipe_d;
    end

  ram_array #(
    .MEM_W   (MEM_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .READ_LAT(STAGES)
  ) u_arr (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .re   (arr_re),
    .addr (arr_addr),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  assign rsp_valid = vld_pipe_q[STAGES];
  assign rsp_err   = rsp_valid && err_pipe_q[STAGES];
  assign rsp_rdata = err_pipe_q[STAGES] ? '0 : arr_rdata[DATA_W-1:0];
`ifdef RAM_PARITY_EN
  assign rsp_perr  = rsp_valid && !err_pipe_q[STAGES] && (^arr_rdata);
`endif

endmodule

// File: tb/tb_ram_param.sv
// Directed bench for ram_param: three instances (latency 1, latency 2,
// short depth) share one request stream; RAM_PARITY_EN adds a parity step.
module tb_ram_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [5:0]  req_addr  = '0;
  logic [15:0] req_wdata = '0;

  logic [2:0]  rdy, vld, err, done;
  logic [15:0] rd [3];
`ifdef RAM_PARITY_EN
  logic [2:0]  perr;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int c0, c1, c2;

  ram_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .READ_LAT(1), .CLEAR_VAL(16'hA5A5)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld[0]), .rsp_rdata(rd[0]),
    .rsp_err(err[0]), .init_done(done[0])
`ifdef RAM_PARITY_EN
    , .rsp_perr(perr[0])
`endif
  );

  ram_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(64), .READ_LAT(2), .CLEAR_VAL(16'hA5A5)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld[1]), .rsp_rdata(rd[1]),
    .rsp_err(err[1]), .init_done(done[1])
`ifdef RAM_PARITY_EN
    , .rsp_perr(perr[1])
`endif
  );

  ram_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(48), .READ_LAT(1), .CLEAR_VAL(16'h5A5A)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(vld[2]), .rsp_rdata(rd[2]),
    .rsp_err(err[2]), .init_done(done[2])
`ifdef RAM_PARITY_EN
    , .rsp_perr(perr[2])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Response check for instance u; data is only meaningful when valid.
  task automatic rsp(input int u, input logic v, input logic [15:0] d, input logic e, input string tag);
    chk($sformatf("%s_u%0d_vld", tag, u), 32'(vld[u]), 32'(v));
    chk($sformatf("%s_u%0d_err", tag, u), 32'(err[u]), 32'(v & e));
    if (v) chk($sformatf("%s_u%0d_data", tag, u), 32'(rd[u]), 32'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [5:0] a, input logic [15:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
  endtask

  // Counts edges after release until each instance reports init_done.
  task automatic wait_done(output int w0, output int w1, output int w2);
    w0 = 0; w1 = 0; w2 = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (done[0] && w0 == 0) w0 = i;
      if (done[1] && w1 == 0) w1 = i;
      if (done[2] && w2 == 0) w2 = i;
      if (w0 != 0 && w1 != 0 && w2 != 0) break;
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_ready", 32'(rdy[0]), 32'd0);
    chk("rst_vld",   32'(vld[0]), 32'd0);
    chk("rst_rdata", 32'(rd[0]),  32'd0);
    chk("rst_err",   32'(err[0]), 32'd0);
    chk("rst_done",  32'(done),   32'd0);

    rst = 1'b1;
    wait_done(c0, c1, c2);
    chk("clr_cycles_d64",   32'(c0), 32'd64);
    chk("clr_cycles_lat2",  32'(c1), 32'd64);
    chk("clr_cycles_d48",   32'(c2), 32'd48);
    chk("ready_after_clr",  32'(rdy), 32'h7);

    req(1'b0, 6'd0, 16'h0);
    rsp(0, 1, 16'hA5A5, 0, "rd0"); rsp(1, 0, 0, 0, "rd0"); rsp(2, 1, 16'h5A5A, 0, "rd0");
    req(1'b0, 6'd63, 16'h0);
    rsp(0, 1, 16'hA5A5, 0, "rd63"); rsp(1, 1, 16'hA5A5, 0, "rd63"); rsp(2, 1, 16'h0, 1, "rd63");
    req(1'b1, 6'd5, 16'h1234);
    rsp(1, 1, 16'hA5A5, 0, "wr5"); rsp(0, 0, 0, 0, "wr5"); rsp(2, 0, 0, 0, "wr5");
    chk("hold_u0", 32'(rd[0]), 32'hA5A5);
    chk("hold_err_u2", 32'(rd[2]), 32'h0);
    req(1'b0, 6'd5, 16'h0);
    rsp(0, 1, 16'h1234, 0, "rd5"); rsp(1, 0, 0, 0, "rd5"); rsp(2, 1, 16'h1234, 0, "rd5");
    req(1'b1, 6'd50, 16'hFFFF);
    rsp(1, 1, 16'h1234, 0, "wr50"); rsp(0, 0, 0, 0, "wr50");
    req(1'b0, 6'd50, 16'h0);
    rsp(0, 1, 16'hFFFF, 0, "rd50"); rsp(1, 0, 0, 0, "rd50"); rsp(2, 1, 16'h0, 1, "rd50");
    req(1'b0, 6'd47, 16'h0);
    rsp(0, 1, 16'hA5A5, 0, "rd47"); rsp(1, 1, 16'hFFFF, 0, "rd47"); rsp(2, 1, 16'h5A5A, 0, "rd47");

    req(1'b1, 6'd1, 16'h0011);
    rsp(1, 1, 16'hA5A5, 0, "wr1");
    req(1'b1, 6'd2, 16'h0022);
    req(1'b1, 6'd3, 16'h0033);
    req(1'b0, 6'd1, 16'h0);
    rsp(0, 1, 16'h0011, 0, "b2b1"); rsp(1, 0, 0, 0, "b2b1");
    req(1'b0, 6'd2, 16'h0);
    rsp(0, 1, 16'h0022, 0, "b2b2"); rsp(1, 1, 16'h0011, 0, "b2b2");
    req(1'b0, 6'd3, 16'h0);
    rsp(0, 1, 16'h0033, 0, "b2b3"); rsp(1, 1, 16'h0022, 0, "b2b3");
    tick();
    rsp(0, 0, 0, 0, "b2b4"); rsp(1, 1, 16'h0033, 0, "b2b4");
    chk("hold_u0_b2b", 32'(rd[0]), 32'h0033);
    tick();
    rsp(1, 0, 0, 0, "b2b5");

    // Reset with a read in flight on the latency-2 instance.
    req(1'b0, 6'd1, 16'h0);
    rsp(0, 1, 16'h0011, 0, "inflt");
    rst = 1'b0;
    #1;
    chk("rst_drop_vld_u0", 32'(vld[0]), 32'd0);
    chk("rst_drop_rd_u0",  32'(rd[0]),  32'd0);
    tick();
    chk("rst_drop_vld_u1", 32'(vld[1]), 32'd0);
    rst = 1'b1;
    repeat (20) tick();
    chk("midclr_done", 32'(done[0]), 32'd0);
    chk("midclr_rdy",  32'(rdy[0]),  32'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    wait_done(c0, c1, c2);
    chk("reclr_cycles_d64", 32'(c0), 32'd64);
    chk("reclr_cycles_d48", 32'(c2), 32'd48);
    req(1'b0, 6'd1, 16'h0);
    rsp(0, 1, 16'hA5A5, 0, "reclr_rd1");

`ifdef RAM_PARITY_EN
    u0.u_arr.mem[7] <= u0.u_arr.mem[7] ^ 17'h1;
    tick();
    req(1'b0, 6'd7, 16'h0);
    rsp(0, 1, 16'hA5A4, 0, "par7");
    chk("perr_addr7", 32'(perr[0]), 32'd1);
    req(1'b0, 6'd8, 16'h0);
    rsp(0, 1, 16'hA5A5, 0, "par8");
    chk("perr_addr8", 32'(perr[0]), 32'd0);
    req(1'b0, 6'd50, 16'h0);
    chk("perr_oor", 32'(perr[2]), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_param.md
# ram_param

Parametrised synchronous single-port RAM with a valid/ready request port, a pipelined read response, and a hardware clear engine that initialises every word after reset. It replaces the fixed 64×16 inferred RAM as the processor's instruction/data store and is the block the CPU fetch and load/store paths talk to. Width, depth, read latency and clear value are generic; out-of-range addresses are flagged.

## Interface
- DATA_W, 16, data word width in bits
- ADDR_W, 6, address width in bits
- DEPTH, 64, number of words; 1 ≤ DEPTH ≤ 2**ADDR_W
- READ_LAT, 1, read latency in cycles; legal values 1 or 2
- CLEAR_VAL, 0, DATA_W-bit value written to every word by the clear engine
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  reset, asynchronous assert, active-low (0 = reset)
- req_valid  input  1  request present
- req_ready  output  1  block accepts request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  read data valid, one-cycle pulse per accepted read
- rsp_rdata  output  DATA_W  read data
- rsp_err  output  1  accepted read was out of range; qualified by rsp_valid
- init_done  output  1  clear engine finished; stays high until next reset

## Operation
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, state=CLEAR, clear counter=0. Memory array itself is not reset.
- FSM states: CLEAR, READY.
- CLEAR: each cycle writes CLEAR_VAL to address = counter, counter += 1; after writing DEPTH-1 go to READY. req_ready=0 throughout.
- READY: req_ready=1 permanently; init_done=1. No return to CLEAR except via rst.
- Transfer occurs on a rising edge with req_valid && req_ready.
- Write transfer: if req_addr < DEPTH, store req_wdata; else discard silently. No response.
- Read transfer: if req_addr < DEPTH, return stored word, rsp_err=0; else rsp_rdata=0, rsp_err=1.
- Reads fully pipelined: one accepted per cycle, responses in request order, no backpressure on response side.
- Write then read of same address on consecutive cycles returns the new data.
- rsp_rdata holds its last value when rsp_valid=0; rsp_err forced 0 when rsp_valid=0.
- rst asserted mid-clear or mid-read: in-flight responses dropped (rsp_valid=0 immediately), clear restarts from address 0 after release.

## Timing
- Clear: DEPTH cycles starting first edge after rst deasserts; init_done and req_ready rise on the edge after the last clear write (cycle DEPTH+1 relative to release edge 0... i.e. after DEPTH clear edges).
- Read accepted at edge N → rsp_valid=1 during cycle after edge N+READ_LAT-1 (READ_LAT=1: visible right after edge N; READ_LAT=2: one cycle later).
- Back-to-back reads at edges N, N+1 → rsp_valid high two consecutive cycles.
- Write at edge N visible to a read accepted at edge N+1.

## Configuration
- RAM_PARITY_EN defined: array stores DATA_W+1 bits (even parity); clear engine writes matching parity; extra output rsp_perr (1 bit, reset 0, qualified by rsp_valid) asserts when stored parity mismatches on an in-range read; out-of-range reads give rsp_perr=0.
- Not defined: array is DATA_W bits, no rsp_perr port, no parity logic.

## Structure
- Shared package ram_pkg: FSM state enum (CLEAR, READY), READ_LAT legal-value constants, parity helper function.
- Sub-module ram_array: pure storage, synchronous write, registered read, output register stage when READ_LAT=2; control (FSM, clear counter, range check, valid/err pipeline) stays in ram_param.

## Test plan
- Reset release, DEPTH=64, CLEAR_VAL=16'hA5A5 → req_ready/init_done low 64 cycles then high; reads of addr 0, 63 return 16'hA5A5.
- Write 16'h1234 to addr 5, read addr 5 next cycle → rsp_valid after READ_LAT cycles, rsp_rdata=16'h1234, rsp_err=0; run with READ_LAT=1 and 2.
- DEPTH=48, ADDR_W=6: write 16'hFFFF to addr 50, read addr 50 → rsp_rdata=0, rsp_err=1; read addr 47 → CLEAR_VAL, rsp_err=0.
- Reads of addrs 1,2,3 on consecutive cycles after writing 11,22,33 → three consecutive rsp_valid cycles, data 11,22,33 in order.
- Assert rst at clear counter=20, release → clear restarts, init_done rises exactly 64 cycles after release; in-flight read response suppressed.
- RAM_PARITY_EN: force one array bit flip at addr 7 via backdoor, read addr 7 → rsp_perr=1; clean addr 8 → rsp_perr=0.
